// File: rtl/cpu_pkg.sv
// cpu_pkg: branch-type encodings, condition codes and flag bit indices shared by the CPU datapath
package cpu_pkg;
   typedef enum logic [1:0] {BR_SEQ, BR_BCOND, BR_JCOND, BR_JAL} br_type_e;
   typedef enum logic [3:0] {
      CC_EQ, CC_NE, CC_CS, CC_CC, CC_HI, CC_LS, CC_GT, CC_LE,
      CC_FS, CC_FC, CC_LO, CC_HS, CC_LT, CC_GE, CC_UC, CC_NV
   } cond_e;
   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;
endpackage

// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if: control/branch request bus between the CPU FSM side and the PC unit
interface pc_branch_unit_if #(parameter int ADDR_W = 16);
   logic              PC_enable;
   logic              flags_we;
   logic [4:0]        alu_flags;
   logic [1:0]        br_type;
   logic [3:0]        cond;
   logic [7:0]        disp;
   logic [ADDR_W-1:0] jtarget;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] link_addr;
   logic [4:0]        flags;
   logic              taken;
   logic [15:0]       br_count;
   modport master (output PC_enable, flags_we, alu_flags, br_type, cond, disp, jtarget,
                   input pc, link_addr, flags, taken, br_count);
   modport slave (input PC_enable, flags_we, alu_flags, br_type, cond, disp, jtarget,
                  output pc, link_addr, flags, taken, br_count);
endinterface

// File: rtl/pc_branch_unit_cond_eval.sv
// cond_eval: maps a 4-bit condition code and {C,L,F,Z,N} flags to a take decision
module cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       take
);
   logic        c, l, f, z, n;
   logic [15:0] tbl;
   always_comb begin
      c = flags[FLAG_C];
      l = flags[FLAG_L];
      f = flags[FLAG_F];
      z = flags[FLAG_Z];
      n = flags[FLAG_N];
      tbl = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f,
             !n, n, !l, l, !c, c, !z, z};
      take = tbl[cond];
   end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register, flag register and branch resolution; PC_BRANCH_CNT_EN adds a taken-redirect counter
module pc_branch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input logic             clk,
   input logic             reset,
   pc_branch_unit_if.slave bus
);
   logic [ADDR_W-1:0] pc_q, pc_d, seq, rel, tgt;
   logic [4:0]        flags_q, flags_d;
   logic              taken_q, taken_d, take, redirect;
   cond_eval u_cond (.cond(bus.cond), .flags(flags_q), .take(take));
   always_comb begin
      seq = pc_q + ADDR_W'(1);
      rel = pc_q + ADDR_W'($signed(bus.disp));
      redirect = bus.br_type == BR_JAL || (take && bus.br_type != BR_SEQ);
      tgt = bus.br_type == BR_BCOND ? rel : bus.jtarget;
      pc_d = !bus.PC_enable ? pc_q : redirect ? tgt : seq;
      taken_d = bus.PC_enable && redirect;
      flags_d = bus.flags_we ? bus.alu_flags : flags_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_VEC;
         flags_q <= '0;
         taken_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         flags_q <= flags_d;
         taken_q <= taken_d;
      end
   end
   assign bus.pc        = pc_q;
   assign bus.link_addr = seq;
   assign bus.flags     = flags_q;
   assign bus.taken     = taken_q;
`ifdef PC_BRANCH_CNT_EN
   logic [15:0] cnt_q, cnt_d;
   always_comb cnt_d = (taken_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign bus.br_count = cnt_q;
`else
   assign bus.br_count = '0;
`endif
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed self-checking bench for pc_branch_unit
module tb_pc_branch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
`ifdef PC_BRANCH_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif
   pc_branch_unit_if #(.ADDR_W(16)) bus ();
   pc_branch_unit #(.ADDR_W(16), .RESET_VEC(16'h0000)) dut (.clk(clk), .reset(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic go(input logic en, input logic fwe, input logic [4:0] af, input logic [1:0] bt,
                     input logic [3:0] cc, input logic [7:0] d, input logic [15:0] jt);
      bus.PC_enable = en;
      bus.flags_we  = fwe;
      bus.alu_flags = af;
      bus.br_type   = bt;
      bus.cond      = cc;
      bus.disp      = d;
      bus.jtarget   = jt;
      @(posedge clk);
      #1;
      bus.PC_enable = 1'b0;
      bus.flags_we  = 1'b0;
   endtask
   initial begin
      bus.PC_enable = 0; bus.flags_we = 0; bus.alu_flags = 0; bus.br_type = 0;
      bus.cond = 0; bus.disp = 0; bus.jtarget = 0;
      #12;
      chk("rst_pc", bus.pc, 16'h0000);
      chk("rst_flags", bus.flags, 5'h00);
      chk("rst_taken", bus.taken, 1'b0);
      chk("rst_cnt", bus.br_count, 16'h0000);
      @(negedge clk) rst_n = 1'b1;
      go(1, 0, 0, 2'b00, 4'h0, 8'h00, 16'h0); chk("seq1", bus.pc, 16'h0001); chk("seq1_tk", bus.taken, 0);
      go(1, 0, 0, 2'b00, 4'h0, 8'h00, 16'h0); chk("seq2", bus.pc, 16'h0002); chk("seq2_tk", bus.taken, 0);
      go(1, 0, 0, 2'b00, 4'h0, 8'h00, 16'h0); chk("seq3", bus.pc, 16'h0003); chk("seq3_tk", bus.taken, 0);
      go(1, 0, 0, 2'b11, 4'hF, 8'h00, 16'h0010); chk("jal10", bus.pc, 16'h0010); chk("jal10_tk", bus.taken, 1);
      go(0, 1, 5'b00010, 2'b00, 4'h0, 8'h00, 16'h0);
      chk("hold_pc", bus.pc, 16'h0010); chk("hold_tk", bus.taken, 0); chk("flagsZ", bus.flags, 5'b00010);
      go(1, 0, 0, 2'b01, 4'h0, 8'hFC, 16'h0); chk("beq_tk_pc", bus.pc, 16'h000C); chk("beq_tk", bus.taken, 1);
      go(0, 0, 0, 2'b00, 4'h0, 8'h00, 16'h0); chk("tk_pulse", bus.taken, 0); chk("idle_pc", bus.pc, 16'h000C);
      go(1, 1, 5'b00000, 2'b11, 4'h0, 8'h00, 16'h0010); chk("jal10b", bus.pc, 16'h0010); chk("flags0", bus.flags, 5'h00);
      go(1, 0, 0, 2'b01, 4'h0, 8'hFC, 16'h0); chk("beq_nt_pc", bus.pc, 16'h0011); chk("beq_nt", bus.taken, 0);
      go(1, 1, 5'b00010, 2'b01, 4'h1, 8'h05, 16'h0);
      chk("bne_old_pc", bus.pc, 16'h0016); chk("bne_old_tk", bus.taken, 1); chk("bne_newf", bus.flags, 5'b00010);
      go(1, 0, 0, 2'b11, 4'h0, 8'h00, 16'h0040); chk("jal40", bus.pc, 16'h0040);
      bus.PC_enable = 1; bus.br_type = 2'b11; bus.cond = 4'hF; bus.jtarget = 16'h1234;
      #1;
      chk("link", bus.link_addr, 16'h0041);
      go(1, 0, 0, 2'b11, 4'hF, 8'h00, 16'h1234); chk("jal1234", bus.pc, 16'h1234); chk("jal_tk", bus.taken, 1);
      go(1, 0, 0, 2'b10, 4'hF, 8'h00, 16'h5555); chk("jnv_pc", bus.pc, 16'h1235); chk("jnv_tk", bus.taken, 0);
      go(1, 0, 0, 2'b10, 4'hE, 8'h00, 16'h1236); chk("juc_pc", bus.pc, 16'h1236); chk("juc_tk", bus.taken, 1);
      go(1, 0, 0, 2'b11, 4'h0, 8'h00, 16'hFFFF); chk("link_wrap", bus.link_addr, 16'h0000);
      go(1, 0, 0, 2'b00, 4'h0, 8'h00, 16'h0); chk("pc_wrap", bus.pc, 16'h0000);
      go(1, 0, 0, 2'b11, 4'h0, 8'h00, 16'h0002);
      go(1, 0, 0, 2'b01, 4'hE, 8'hFC, 16'h0); chk("disp_wrap", bus.pc, 16'hFFFE); chk("dw_tk", bus.taken, 1);
      go(0, 0, 0, 2'b00, 4'h0, 8'h00, 16'h0);
      go(0, 0, 0, 2'b01, 4'hE, 8'h10, 16'h0); chk("hold2", bus.pc, 16'hFFFE);
      chk("cnt_run", bus.br_count, CNT_ON ? 16'd10 : 16'd0);
      bus.PC_enable = 1; bus.br_type = 2'b00;
      #3 rst_n = 1'b0;
      #1;
      chk("async_pc", bus.pc, 16'h0000);
      chk("async_flags", bus.flags, 5'h00);
      chk("async_cnt", bus.br_count, 16'h0000);
      @(posedge clk); #1;
      chk("rst_hold_pc", bus.pc, 16'h0000);
      @(negedge clk) begin rst_n = 1'b1; bus.PC_enable = 0; end
      go(1, 0, 0, 2'b10, 4'hE, 8'h00, 16'h0100);
      go(1, 0, 0, 2'b10, 4'hE, 8'h00, 16'h0200);
      go(1, 0, 0, 2'b10, 4'hE, 8'h00, 16'h0300); chk("j3_pc", bus.pc, 16'h0300);
      chk("cnt3", bus.br_count, CNT_ON ? 16'd3 : 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
